// File: rtl/log_compress.sv
// Mel-energy log2 compression: one filter per clock through a leading-one
// detector with linear mantissa, then the whole vector is published at once.

module log2_fx #(
  parameter int ENERGY_WIDTH = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 10
) (
  input  logic [ENERGY_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0]   y
);
  localparam int PW = $clog2(ENERGY_WIDTH);

  logic [PW-1:0]           p;
  logic [ENERGY_WIDTH-1:0] al;

  // x==0 falls through as p=0, mantissa 0, which is the clamped log(0)
  always_comb begin
    p = '0;
    for (int i = 1; i < ENERGY_WIDTH; i++)
      if (x[i]) p = PW'(i);
    al = x << (PW'(ENERGY_WIDTH - 1) - p);
    y  = {{(DATA_WIDTH - PW - FRAC_BITS){1'b0}}, p, al[ENERGY_WIDTH-2 -: FRAC_BITS]};
  end
endmodule

module log_compress #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_FILTERS  = 26,
  parameter int ENERGY_WIDTH = 32,
  parameter int FRAC_BITS    = 10
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [0:NUM_FILTERS-1][ENERGY_WIDTH-1:0] mel_in,
  input  logic                                     mel_valid,
  output logic [0:NUM_FILTERS-1][DATA_WIDTH-1:0]   log_out,
  output logic                                     log_valid,
  output logic                                     busy,
  output logic                                     overrun
);
  localparam int IW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                                   state, state_nx;
  logic [IW-1:0]                            idx;
  logic [0:NUM_FILTERS-1][ENERGY_WIDTH-1:0] latch;
  logic [0:NUM_FILTERS-1][DATA_WIDTH-1:0]   shadow;
  logic [DATA_WIDTH-1:0]                    conv;
  logic                                     accept, last;

  log2_fx #(
    .ENERGY_WIDTH(ENERGY_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) u_conv (
    .x(latch[idx]),
    .y(conv)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = (idx == IW'(NUM_FILTERS - 1));
    case (state)
      IDLE: if (mel_valid) begin
        accept   = 1'b1;
        state_nx = CALC;
      end
      CALC: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      latch     <= '0;
      shadow    <= '0;
      log_out   <= '0;
      log_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      log_valid <= (state == DONE);
      overrun   <= mel_valid && (state != IDLE);
      if (accept) begin
        latch <= mel_in;
        idx   <= '0;
      end
      if (state == CALC) begin
        shadow[idx] <= conv;
        idx         <= last ? '0 : idx + 1'b1;
      end
      // publish only here so downstream sees a stable vector during CALC
      if (state == DONE) log_out <= shadow;
    end
  end
endmodule

// File: tb/tb_log_compress.sv
// Randomized bench for log_compress against an arithmetic log2 model.

module tb_log_compress;
  localparam int NF = 26;
  localparam int EW = 32;
  localparam int DW = 16;
  localparam int FB = 10;
  localparam int LAT = NF + 2;

  typedef logic [0:NF-1][EW-1:0] frame_t;
  typedef logic [0:NF-1][DW-1:0] vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  frame_t mel_in;
  logic   mel_valid;
  vec_t   log_out;
  logic   log_valid, busy, overrun;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t exp_out;

  always #5 clk = ~clk;

  log_compress #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .ENERGY_WIDTH(EW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .mel_in(mel_in), .mel_valid(mel_valid),
    .log_out(log_out), .log_valid(log_valid), .busy(busy), .overrun(overrun)
  );

  function automatic logic [DW-1:0] ref_log(input logic [EW-1:0] x);
    longint v, r, m;
    int p;
    v = longint'(x);
    if (v == 0) return '0;
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    r = v - (longint'(1) << p);
    if (p >= FB) m = r >> (p - FB);
    else         m = r << (FB - p);
    return DW'(p * (1 << FB) + m);
  endfunction

  function automatic vec_t ref_vec(input frame_t f);
    vec_t v;
    for (int i = 0; i < NF; i++) v[i] = ref_log(f[i]);
    return v;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NF; i++) f[i] = $urandom >> $urandom_range(0, 31);
    return f;
  endfunction

  // Strobe one frame at the current negedge; lat = negedges until log_valid, -1 on timeout
  task automatic run_frame(input frame_t f, output int lat);
    mel_in = f;
    mel_valid = 1'b1;
    lat = -1;
    for (int n = 1; n <= 3 * LAT; n++) begin
      @(negedge clk);
      if (n == 1) mel_valid = 1'b0;
      if (log_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({log_valid, busy, overrun} !== 3'b000 || log_out !== '0)
      $display("FAIL reset_hold: flags=%b out=%h required flags=000 out=0", {log_valid, busy, overrun}, log_out);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({log_valid, busy, overrun} !== 3'b000 || log_out !== '0)
      $display("FAIL reset_idle: flags=%b out=%h required flags=000 out=0", {log_valid, busy, overrun}, log_out);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    frame_t f = '0;
    vec_t   e = '0;
    int     lat;
    f[0] = 32'd0; f[1] = 32'd1; f[2] = 32'd2; f[3] = 32'd3; f[4] = 32'd1024; f[5] = 32'd1536;
    e[0] = 16'd0; e[1] = 16'd0; e[2] = 16'd1024; e[3] = 16'd1536; e[4] = 16'd10240; e[5] = 16'd10752;
    mel_in = f;
    mel_valid = 1'b1;
    @(negedge clk);
    mel_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL directed_busy: busy=%b required 1", busy);
    else pass_cnt++;
    lat = -1;
    for (int n = 2; n <= 3 * LAT; n++) begin
      @(negedge clk);
      if (log_valid) begin lat = n; break; end
    end
    total_cnt++;
    if (lat != LAT) $display("FAIL directed_latency: got %0d required %0d", lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (log_out !== e) $display("FAIL directed_out: got %h required %h", log_out, e);
    else pass_cnt++;
    exp_out = e;
    @(negedge clk);
    total_cnt++;
    if ({log_valid, busy} !== 2'b00) $display("FAIL directed_pulse: valid,busy=%b required 00", {log_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    frame_t f = '1;
    vec_t   e;
    int     lat;
    for (int i = 0; i < NF; i++) e[i] = 16'd32767;
    run_frame(f, lat);
    total_cnt++;
    if (lat != LAT) $display("FAIL saturate_latency: got %0d required %0d", lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (log_out !== e) $display("FAIL saturate_out: got %h required %h", log_out, e);
    else pass_cnt++;
    exp_out = e;
    @(negedge clk);
  endtask

  task automatic test_latch_isolation();
    frame_t f = rand_frame();
    int     lat = -1;
    mel_in = f;
    mel_valid = 1'b1;
    for (int n = 1; n <= 3 * LAT; n++) begin
      @(negedge clk);
      mel_valid = 1'b0;
      mel_in = rand_frame();
      if (log_valid) begin lat = n; break; end
    end
    exp_out = ref_vec(f);
    total_cnt++;
    if (lat != LAT) $display("FAIL isolate_latency: got %0d required %0d", lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (log_out !== exp_out) $display("FAIL isolate_out: got %h required %h", log_out, exp_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t fa = rand_frame();
    frame_t fb = rand_frame();
    vec_t   ea = ref_vec(fa);
    vec_t   eb = ref_vec(fb);
    int     lat, bad = 0;
    run_frame(fa, lat);
    total_cnt++;
    if (lat != LAT || log_out !== ea) $display("FAIL b2b_a: lat=%0d out=%h required lat=%0d out=%h", lat, log_out, LAT, ea);
    else pass_cnt++;
    mel_in = fb;
    mel_valid = 1'b1;
    lat = -1;
    for (int n = 1; n <= 3 * LAT; n++) begin
      @(negedge clk);
      mel_valid = 1'b0;
      mel_in = rand_frame();
      if (log_valid) begin lat = n; break; end
      if (log_out !== ea) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL b2b_hold: %0d cycles changed required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (lat != LAT || log_out !== eb) $display("FAIL b2b_b: lat=%0d out=%h required lat=%0d out=%h", lat, log_out, LAT, eb);
    else pass_cnt++;
    exp_out = eb;
    @(negedge clk);
  endtask

  task automatic test_continuous();
    frame_t frames[0:86];
    logic   ev, eo;
    for (int k = 0; k <= 86; k++) begin
      if (k > 0) begin
        ev = (k == LAT) || (k == 2 * LAT) || (k == 3 * LAT);
        eo = (k >= 2) && (k <= 2 * LAT + 1) && ((k % LAT) != 1);
        if (ev) exp_out = ref_vec(frames[k - LAT]);
        total_cnt++;
        if (log_valid !== ev) $display("FAIL cont_valid k=%0d: got %b required %b", k, log_valid, ev);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== eo) $display("FAIL cont_overrun k=%0d: got %b required %b", k, overrun, eo);
        else pass_cnt++;
        total_cnt++;
        if (log_out !== exp_out) $display("FAIL cont_out k=%0d: got %h required %h", k, log_out, exp_out);
        else pass_cnt++;
      end
      frames[k] = rand_frame();
      mel_in = frames[k];
      mel_valid = (k <= 2 * LAT);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    frame_t f;
    int     lat;
    for (int t = 0; t < 4; t++) begin
      f = rand_frame();
      run_frame(f, lat);
      exp_out = ref_vec(f);
      total_cnt++;
      if (lat != LAT) $display("FAIL rand_latency t=%0d: got %0d required %0d", t, lat, LAT);
      else pass_cnt++;
      total_cnt++;
      if (log_out !== exp_out) $display("FAIL rand_out t=%0d: got %h required %h", t, log_out, exp_out);
      else pass_cnt++;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    mel_in = rand_frame();
    mel_valid = 1'b1;
    @(negedge clk);
    mel_valid = 1'b0;
    repeat (9) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || log_out !== '0) $display("FAIL midrst_async: busy=%b out=%h required busy=0 out=0", busy, log_out);
    else pass_cnt++;
    exp_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(negedge clk);
      if (log_valid) seen++;
    end
    total_cnt++;
    if (seen != 0 || log_out !== exp_out) $display("FAIL midrst_no_valid: pulses=%0d out=%h required 0 and 0", seen, log_out);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    mel_valid = 1'b0;
    mel_in = '0;
    exp_out = '0;
    test_reset();
    test_directed();
    test_saturate();
    test_latch_isolation();
    test_back_to_back();
    test_continuous();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/log_compress.md
Name: log_compress

Overview:
- Log-compression stage between the mel filterbank and the DCT stage.
- Takes one frame of NUM_FILTERS unsigned mel energies and computes a fixed-point log2 of each, one filter per clock, using a leading-one detector with linear mantissa approximation.
- When all filters are done, presents the vector as signed DATA_WIDTH values with a one-cycle valid pulse, in the format the DCT's log_in/log_valid inputs expect.

Parameters:
- DATA_WIDTH, 16, width of each signed log output.
- NUM_FILTERS, 26, mel filters per frame.
- ENERGY_WIDTH, 32, width of each unsigned mel energy input.
- FRAC_BITS, 10, fractional bits of the log2 output. Constraint: $clog2(ENERGY_WIDTH)+FRAC_BITS <= DATA_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- mel_in  in  ENERGY_WIDTH x [0:NUM_FILTERS-1]  unsigned mel energies.
- mel_valid  in  1  frame-present strobe.
- log_out  out  signed DATA_WIDTH x [0:NUM_FILTERS-1]  log2 energies.
- log_valid  out  1  one-cycle pulse when log_out holds a new frame.
- busy  out  1  high while a frame is being processed.
- overrun  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; index counter to 0.
  - All log_out entries, the shadow buffer and the input latch go to 0.
  - log_valid, busy and overrun go to 0.
  - Reset mid-frame abandons the frame. No log_valid is produced for it.
- FSM states: IDLE, CALC, DONE.
  - IDLE: mel_valid=1 latches all of mel_in into the input latch, clears the index, goes to CALC.
  - CALC: each cycle converts latch[index] and writes it to shadow[index]. Index increments. At index==NUM_FILTERS-1, after that write, go to DONE.
  - DONE: copy shadow into log_out, pulse log_valid for this cycle only, return to IDLE.
- Latency: mel_valid accepted at edge T. Conversions happen on edges T+1..T+NUM_FILTERS. log_valid is high in the cycle after edge T+NUM_FILTERS+1. Frame-to-frame throughput is NUM_FILTERS+2 cycles.
- busy: high in every cycle the state is CALC or DONE; low in IDLE.
- Output stability: log_out changes only at DONE. It holds the previous frame while CALC runs, so the downstream stage always sees a stable vector.
- Dropped frames:
  - mel_valid is accepted only in IDLE.
  - mel_valid=1 in CALC or DONE drops that frame and pulses overrun for one cycle, registered on the next edge.
  - mel_in is ignored outside the acceptance edge. Only the latched copy is used.
- Conversion for input x:
  - If x==0, treat it as x=1. Result is 0; log(0) is clamped.
  - p = bit position of the most significant 1 (0..ENERGY_WIDTH-1).
  - m = the p bits below the MSB, left-aligned into FRAC_BITS. If p>FRAC_BITS, keep the top FRAC_BITS bits (truncate). If p<FRAC_BITS, zero-pad on the right.
  - Result = (p << FRAC_BITS) + m, zero-extended to DATA_WIDTH.
  - The result is always non-negative and never saturates, given the parameter constraint.
  - No rounding.
- Leading-one detection and alignment are combinational within the single CALC cycle.

Test Plan:
- Reset then idle: log_out all 0, log_valid/busy/overrun 0. Assert rst_n low mid-CALC: busy drops asynchronously, no log_valid follows.
- Frame with mel_in[0..5] = 0, 1, 2, 3, 1024, 1536 and the rest 0:
  - log_out[0..5] = 0, 0, 1024, 1536, 10240, 10752; remaining entries 0.
  - log_valid is a single pulse exactly NUM_FILTERS+2 cycles after the mel_valid cycle.
- All inputs 32'hFFFFFFFF: every log_out = 32767 (p=31, m=1023).
- mel_valid held high continuously for 3 frames:
  - Frames accepted only from IDLE, i.e. every 28 cycles with defaults.
  - overrun pulses once for each dropped-strobe cycle.
  - log_out changes only on log_valid cycles.
- mel_in changed while busy: the output reflects only the values latched at acceptance.
- Back-to-back frames A then B, B strobed in the first IDLE cycle after A's DONE:
  - log_out holds A during all of B's CALC cycles, then switches to B with B's log_valid pulse.
